// File: rtl/pipe_out_buffer.sv
// Output buffer for a fixed-latency, no-backpressure hash pipeline: credit-based issue
// control, a FIFO with first-word fall-through, and a valid/ready output. Optional macro: PIPE_OUT_BUF_STATS_EN.
module pipe_out_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NPIPE_DEPTH = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          issue_ready,
  input  logic                          issue_valid,
  input  logic                          pipe_valid,
  input  logic [DATA_WIDTH-1:0]         pipe_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          proto_err
`ifdef PIPE_OUT_BUF_STATS_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int IW = $clog2(NPIPE_DEPTH + FIFO_DEPTH) + 1;
  localparam int SW = IW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic                  out_valid_q, out_valid_d;
  logic                  proto_err_q, proto_err_d;

  logic [SW-1:0]         credit_sum;
  logic                  credit;
  logic                  full;
  logic                  arrival_ok;
  logic                  push;
  logic                  pop;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    credit_sum  = SW'(occ_q) + SW'(inflight_q);
    credit      = credit_sum < SW'(FIFO_DEPTH);
    full        = (occ_q == OW'(FIFO_DEPTH));
    pop         = out_valid_q && out_ready;
    arrival_ok  = pipe_valid && (inflight_q != '0);
    // A push into a full FIFO only survives if a pop frees the slot in the same cycle.
    push        = arrival_ok && (!full || pop);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    inflight_d  = inflight_q;
    proto_err_d = proto_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    case ({issue_valid, arrival_ok})
      2'b10:   if (inflight_q != '1) inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    if ((issue_valid && !credit) || (pipe_valid && (inflight_q == '0)))
      proto_err_d = 1'b1;

    out_valid_d = (occ_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      inflight_q  <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: storage is not reset; its contents are only observed when occupancy marks them valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= pipe_data;
  end

  assign issue_ready = credit;
  assign out_valid   = out_valid_q;
  assign out_data    = mem_q[rd_ptr_q];
  assign occupancy   = occ_q;
  assign proto_err   = proto_err_q;

`ifdef PIPE_OUT_BUF_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_out_buffer.sv
// Directed bench for pipe_out_buffer: a 3-stage shift-register model stands in for the
// upstream pipe; expected values are hand-derived for each step.
module tb_pipe_out_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_ready;
  logic        issue_valid = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [31:0] pipe_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  occupancy;
  logic        proto_err;
`ifdef PIPE_OUT_BUF_STATS_EN
  logic [31:0] stall_cycles;
`endif

  pipe_out_buffer #(.DATA_WIDTH(32), .NPIPE_DEPTH(3), .FIFO_DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .pipe_valid  (pipe_valid),
    .pipe_data   (pipe_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .proto_err   (proto_err)
`ifdef PIPE_OUT_BUF_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        s_v [3];
  logic [31:0] s_d [3];
  logic        use_model = 1'b1;
  logic [31:0] issue_data = '0;
  logic        pv_prev = 1'b0;
  int          exp_val;
  int          accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: remembers the pipe_valid seen at the edge, then advances the pipe model.
  task automatic cycle();
    pv_prev = pipe_valid;
    @(posedge clock);
    #1;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        s_v[i] = 1'b0;
        s_d[i] = '0;
      end
    end else begin
      s_v[2] = s_v[1]; s_d[2] = s_d[1];
      s_v[1] = s_v[0]; s_d[1] = s_d[0];
      s_v[0] = issue_valid; s_d[0] = issue_data;
    end
    if (use_model) begin
      pipe_valid = s_v[2];
      pipe_data  = s_d[2];
    end
  endtask

  task automatic do_reset();
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    reset       = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
  endtask

  // Issue whenever credit is offered, with the output stalled; credit must track issued count.
  task automatic fill(output int n_acc);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      issue_valid = issue_ready;
      cycle();
      if (issue_valid) begin
        n_acc++;
        issue_data++;
      end
      check("fill_credit", issue_ready, (n_acc < 8) ? 32'd1 : 32'd0);
    end
    issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      s_v[i] = 1'b0;
      s_d[i] = '0;
    end

    // Reset / idle
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_proto_err", proto_err, 0);

    // Streaming with the consumer always ready
    out_ready  = 1'b1;
    issue_data = 32'd1;
    exp_val    = 1;
    for (int i = 0; i < 16; i++) begin
      issue_valid = (i < 6);
      cycle();
      if (issue_valid) issue_data++;
      check("stream_ready", issue_ready, 1);
      check("stream_occ_le1", {31'd0, occupancy <= 4'd1}, 1);
      check("stream_valid_latency", out_valid, pv_prev);
      if (out_valid) begin
        check("stream_data", out_data, exp_val);
        exp_val++;
      end
    end
    issue_valid = 1'b0;
    check("stream_count", exp_val, 7);

    // Backpressure fill: exactly eight credits, data 7..14
    out_ready = 1'b0;
    fill(accepted);
    check("fill_accepted", accepted, 8);
    check("fill_occupancy", occupancy, 8);
    check("fill_head", out_data, 7);
    check("fill_proto_err", proto_err, 0);

    // Drain: credit returns the cycle after the first pop
    out_ready = 1'b1;
    exp_val   = 7;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, exp_val);
      exp_val++;
      cycle();
      if (i == 0) begin
        check("drain_credit_back", issue_ready, 1);
        check("drain_occ_after_pop", occupancy, 7);
      end
    end
    check("drain_occ_empty", occupancy, 0);
    check("drain_valid_empty", out_valid, 0);

    // Wrap with simultaneous push and pop at occupancy 4
    out_ready   = 1'b0;
    issue_data  = 32'd100;
    issue_valid = 1'b1;
    for (int i = 0; i < 20 && occupancy != 4'd4; i++) begin
      cycle();
      issue_data++;
    end
    check("wrap_occ_start", occupancy, 4);
    check("wrap_head_start", out_data, 100);
    out_ready = 1'b1;
    exp_val   = 101;
    for (int i = 0; i < 20; i++) begin
      cycle();
      issue_data++;
      check("wrap_occ", occupancy, 4);
      check("wrap_data", out_data, exp_val);
      exp_val++;
    end
    check("wrap_credit", issue_ready, 1);
    check("wrap_proto_err", proto_err, 0);

    // Protocol error: issue without credit; the extra arrival is dropped at full
    do_reset();
    issue_data = 32'd200;
    fill(accepted);
    check("err1_accepted", accepted, 8);
    check("err1_before", proto_err, 0);
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    check("err1_set", proto_err, 1);
    repeat (6) cycle();
    check("err1_sticky", proto_err, 1);
    check("err1_occ_full", occupancy, 8);
    check("err1_head", out_data, 200);

    // Protocol error: arrival with nothing in flight is discarded
    do_reset();
    check("err2_cleared", proto_err, 0);
    use_model  = 1'b0;
    pipe_valid = 1'b1;
    pipe_data  = 32'hdead;
    cycle();
    pipe_valid = 1'b0;
    check("err2_set", proto_err, 1);
    check("err2_occ", occupancy, 0);
    check("err2_valid", out_valid, 0);
    cycle();
    use_model = 1'b1;
    check("err2_occ_later", occupancy, 0);
    check("err2_no_underflow", issue_ready, 1);

`ifdef PIPE_OUT_BUF_STATS_EN
    // Stall counter
    do_reset();
    issue_data  = 32'd300;
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) cycle();
    check("stats_word_present", out_valid, 1);
    check("stats_zero", stall_cycles, 0);
    repeat (5) cycle();
    check("stats_five", stall_cycles, 5);
    out_ready = 1'b1;
    cycle();
    check("stats_hold", stall_cycles, 5);
    check("stats_popped", out_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_out_buffer.md
Name: pipe_out_buffer

Overview:
- Downstream stage for the fixed-latency Shift_Register hash pipeline.
- The pipeline has no backpressure: a word issued at its input emerges exactly NPIPE_DEPTH cycles later, whether or not anyone is ready for it.
- This block captures those words in a small FIFO and presents them on a valid/ready output.
- It also issues credits upstream so that no word is ever issued into the pipe without guaranteed buffer space.

Parameters:
- DATA_WIDTH, 32, width of pipeline data and output data.
- NPIPE_DEPTH, 3, latency of the feeding pipeline in cycles; sizes the in-flight counter.
- FIFO_DEPTH, 8, buffer entries; power of two, >= 2.

Ports:
- clock  in  1  single clock domain; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- issue_ready  out  1  credit available: upstream may issue one word into the pipe this cycle.
- issue_valid  in  1  upstream issued one word into the pipe this cycle.
- pipe_valid  in  1  the pipe output word is valid this cycle (the pipe's delayed copy of issue_valid).
- pipe_data  in  DATA_WIDTH  pipe output word (Shift_Register output_data).
- out_valid  out  1  buffer non-empty; out_data is valid.
- out_ready  in  1  consumer accepts out_data when out_valid is also high.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- occupancy  out  $clog2(FIFO_DEPTH)+1  number of words currently stored.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous):
  - Clears FIFO pointers, occupancy, in-flight counter and proto_err.
  - Outputs: out_valid=0, occupancy=0, proto_err=0, issue_ready=1 the cycle after reset deasserts.
  - out_data is don't-care while out_valid=0.
  - Reset mid-operation discards stored and in-flight words. The pipe's valid bits share this reset, so no stale arrivals follow.
- In-flight counter:
  - Width $clog2(NPIPE_DEPTH+FIFO_DEPTH)+1.
  - +1 on issue_valid, -1 on pipe_valid; both in the same cycle leave it unchanged.
- Credit:
  - issue_ready = (occupancy + inflight) < FIFO_DEPTH.
  - Combinational from registers only; no dependence on issue_valid.
  - Pops do not free credit until the cycle after the pop (registered count).
- Push:
  - pipe_valid=1 with inflight>0 writes pipe_data at the write pointer.
  - Latency from pipe_valid to out_valid rising is 1 cycle (registered write, first-word fall-through read).
- Pop:
  - Occurs when out_valid && out_ready; advances the read pointer.
  - out_data = mem[rd_ptr], always the head word.
- Simultaneous push and pop:
  - Both occur; occupancy is unchanged.
  - Legal at full and at empty: at empty no pop can occur, since out_valid=0.
- Pointers:
  - $clog2(FIFO_DEPTH) bits; wrap modulo FIFO_DEPTH.
  - Full/empty is derived from occupancy.
- Ordering: strict FIFO; output order equals issue order.
- proto_err is set (sticky until reset) on either of:
  - issue_valid=1 while issue_ready=0. The issue still counts in inflight.
  - pipe_valid=1 while inflight=0. The word is discarded, and inflight does not underflow.
- Overflow protection: a push when occupancy==FIFO_DEPTH, reachable only after a protocol error, is dropped. The FIFO never corrupts.
- out_valid and occupancy are registered outputs.

Optional Feature:
- Macro: PIPE_OUT_BUF_STATS_EN.
- Defined:
  - Adds output port stall_cycles (32 bits).
  - Counts cycles with out_valid=1 && out_ready=0.
  - Saturates at 2^32-1; cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle: reset high 2 cycles, then low -> out_valid=0, occupancy=0, issue_ready=1, proto_err=0.
- Streaming:
  - Stimulus: out_ready=1; issue every cycle with a Shift_Register(NPIPE_DEPTH=3) model; data 1,2,3...
  - Response: out_data 1,2,3... in order, each 1 cycle after pipe_valid; occupancy <= 1; issue_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0, issue whenever issue_ready.
  - Response: exactly 8 issues accepted; issue_ready falls once occupancy+inflight=8; occupancy reaches 8; no proto_err.
- Drain:
  - Stimulus: then out_ready=1.
  - Response: 8 words out in order; issue_ready returns 1 the cycle after the first pop; occupancy reaches 0.
- Protocol errors:
  - issue_valid with issue_ready=0 -> proto_err=1 and stays 1.
  - Separately, after reset, pipe_valid with no issue -> proto_err=1, word not stored (occupancy=0).
- Wrap/simultaneous: occupancy 4, push+pop every cycle for 20 cycles -> occupancy stays 4, data in order across pointer wrap.
- Stats (PIPE_OUT_BUF_STATS_EN only): hold out_ready=0 for 5 cycles with a word present -> stall_cycles=5.
